frv_mem_arbiter: RTL and testbench
==================================

Name: frv_mem_arbiter

Overview:
- Shares one physical memory port between the fetch stage (instruction requester "i") and the load/store unit (data requester "d").
- Uses the core's req/gnt request handshake and recv/ack response handshake on all three ports. Supports multiple outstanding requests.
- Records the owner of each granted request in an in-order owner FIFO, so each response is steered back to the requester that issued it.
- Data has priority. A starvation counter guarantees fetch progress.

Parameters:
- MAX_OUTSTANDING, 4, depth of owner FIFO = maximum granted-but-unanswered requests (power of 2, ≥2).
- STARVE_LIMIT, 3, consecutive lost contested arbitrations after which fetch wins the next arbitration.

Ports:
- g_clk  input  1  global clock
- g_reset  input  1  asynchronous active-high reset
- i_req  input  1  fetch request
- i_wen  input  1  fetch write enable
- i_strb  input  4  fetch write strobe
- i_wdata  input  32  fetch write data
- i_addr  input  32  fetch address
- i_gnt  output  1  fetch request accepted
- i_recv  output  1  fetch response valid
- i_ack  input  1  fetch accepts response
- i_error  output  1  fetch response error
- i_rdata  output  32  fetch response data
- d_req, d_wen, d_strb, d_wdata, d_addr, d_gnt, d_recv, d_ack, d_error, d_rdata: same directions and widths as the i_* ports, for the data requester
- m_req  output  1  shared memory request
- m_wen  output  1  shared write enable
- m_strb  output  4  shared write strobe
- m_wdata  output  32  shared write data
- m_addr  output  32  shared address
- m_gnt  input  1  memory accepted request
- m_recv  input  1  memory response valid
- m_ack  output  1  arbiter accepts response
- m_error  input  1  response error
- m_rdata  input  32  response data
- arb_err  output  1  sticky: response arrived with no outstanding request

Behaviour:
- Reset state: count=0, lock=0, starve=0, arb_err=0, FIFO pointers=0.
- While g_reset=1, force m_req, i_gnt, d_gnt, i_recv, d_recv, m_ack to 0.
- Request path and response path are both combinational, 0-cycle. All state is registered on posedge g_clk.
- Request handshake rule:
  - A requester holds req and its payload stable until it sees gnt.
  - A request transfers on m_req && m_gnt.
- Selection (sel ∈ {I, D}):
  - If lock=1, sel = locked_sel.
  - Otherwise sel = D if d_req && !(i_req && starve==STARVE_LIMIT); else sel = I.
- Request muxing:
  - m_req = (sel's req) && (count < MAX_OUTSTANDING).
  - m_wen, m_strb, m_wdata, m_addr come from the sel requester.
  - i_gnt = m_gnt && m_req && sel==I; d_gnt likewise for D.
- Lock:
  - Set on m_req && !m_gnt, capturing sel into locked_sel.
  - Cleared on m_req && m_gnt.
  - The mux never switches while a request is stalled.
- Starve counter:
  - On d_gnt while i_req=1: starve increments, saturating at STARVE_LIMIT.
  - On i_gnt: starve clears to 0.
  - Otherwise it holds.
- Owner FIFO:
  - Push sel on m_req && m_gnt.
  - Pop on m_recv && m_ack && count≠0.
  - Simultaneous push and pop leaves count unchanged. Pointers wrap modulo MAX_OUTSTANDING.
  - When full, m_req stays 0, so no push can occur. A pop that cycle frees a slot from the next cycle.
- Response routing, with head = owner at the read pointer:
  - i_recv = m_recv && count≠0 && head==I; d_recv likewise for D.
  - i_rdata, d_rdata and i_error, d_error are driven from m_rdata and m_error unconditionally. They are qualified by recv.
  - m_ack = head==I ? i_ack : d_ack when count≠0.
  - A non-owner's ack is ignored.
  - A stalled response blocks later responses (in-order), but does not block new requests while count < MAX.
- Orphan response (m_recv && count==0): m_ack=1 to drain it, neither recv asserts, and arb_err is set. arb_err clears only on reset.
- Reset mid-operation clears all state immediately. In-flight responses are forfeit; the memory must be reset in the same domain.

Test Plan:
1. Both requesters idle, then d_req=1 at 0x100 with m_gnt=1 → d_gnt=1 the same cycle, count 0→1, FIFO head=D. Then m_recv=1 with m_rdata=0xDEADBEEF and d_ack=1 → d_recv=1, d_rdata=0xDEADBEEF, count→0.
2. i_req and d_req held high continuously with m_gnt=1 → grant sequence D,D,D,I,D,D,D,I… and starve reads 0,1,2,3,0.
3. d_req=1 with m_gnt=0 for 3 cycles, i_req rising in cycle 2 → m_addr stays d_addr and lock=1 throughout. Then m_gnt=1 → d_gnt=1, and fetch is granted only afterwards.
4. Issue I,D,I,D with no responses (MAX_OUTSTANDING=4) → count=4 and m_req=0 despite requests. Then four in-order responses → recv pulses on i,d,i,d. The first pop re-enables m_req on the following cycle.
5. m_recv=1 with count=0 → m_ack=1, i_recv=d_recv=0, arb_err=1 sticky. Then assert g_reset mid-burst with count=3 → count=0, lock=0, arb_err=0, and all outputs listed above are 0 asynchronously.

Source files
------------

// File: rtl/frv_mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto one memory port with req/gnt and recv/ack handshakes.
// An in-order owner FIFO steers each response back to the requester that issued it.
module frv_mem_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 3
) (
  input  logic        g_clk,
  input  logic        g_reset,

  input  logic        i_req,
  input  logic        i_wen,
  input  logic [3:0]  i_strb,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_recv,
  input  logic        i_ack,
  output logic        i_error,
  output logic [31:0] i_rdata,

  input  logic        d_req,
  input  logic        d_wen,
  input  logic [3:0]  d_strb,
  input  logic [31:0] d_wdata,
  input  logic [31:0] d_addr,
  output logic        d_gnt,
  output logic        d_recv,
  input  logic        d_ack,
  output logic        d_error,
  output logic [31:0] d_rdata,

  output logic        m_req,
  output logic        m_wen,
  output logic [3:0]  m_strb,
  output logic [31:0] m_wdata,
  output logic [31:0] m_addr,
  input  logic        m_gnt,
  input  logic        m_recv,
  output logic        m_ack,
  input  logic        m_error,
  input  logic [31:0] m_rdata,

  output logic        arb_err
);

  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  owner_e          owner_q [MAX_OUTSTANDING];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            lock_q, lock_d;
  owner_e          locked_sel_q, locked_sel_d;
  logic            arb_err_q;

  owner_e          sel;
  owner_e          head;
  logic            sel_req;
  logic            has_room;
  logic            nonempty;
  logic            starve_full;
  logic            push, pop, orphan;

  assign starve_full = (starve_q == SW'(STARVE_LIMIT));
  assign has_room    = (count_q < CW'(MAX_OUTSTANDING));
  assign nonempty    = (count_q != '0);
  assign head        = owner_q[rd_ptr_q];

  // A stalled request keeps the mux pinned via lock so the payload cannot switch under it.
  always_comb begin
    sel = OWN_I;
    if (lock_q) begin
      sel = locked_sel_q;
    end else if (d_req && !(i_req && starve_full)) begin
      sel = OWN_D;
    end
  end

  assign sel_req = (sel == OWN_D) ? d_req : i_req;

  assign m_req   = !g_reset && sel_req && has_room;
  assign m_wen   = (sel == OWN_D) ? d_wen   : i_wen;
  assign m_strb  = (sel == OWN_D) ? d_strb  : i_strb;
  assign m_wdata = (sel == OWN_D) ? d_wdata : i_wdata;
  assign m_addr  = (sel == OWN_D) ? d_addr  : i_addr;

  assign i_gnt   = m_req && m_gnt && (sel == OWN_I);
  assign d_gnt   = m_req && m_gnt && (sel == OWN_D);

  assign i_recv  = !g_reset && m_recv && nonempty && (head == OWN_I);
  assign d_recv  = !g_reset && m_recv && nonempty && (head == OWN_D);
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
  assign i_error = m_error;
  assign d_error = m_error;

  // With nothing outstanding, a response is an orphan and is drained unconditionally.
  always_comb begin
    m_ack = 1'b0;
    if (!g_reset) begin
      if (nonempty) begin
        m_ack = (head == OWN_I) ? i_ack : d_ack;
      end else begin
        m_ack = m_recv;
      end
    end
  end

  assign push    = m_req && m_gnt;
  assign pop     = m_recv && m_ack && nonempty;
  assign orphan  = !g_reset && m_recv && !nonempty;
  assign arb_err = arb_err_q;

  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);

    starve_d = starve_q;
    if (i_gnt) begin
      starve_d = '0;
    end else if (d_gnt && i_req && !starve_full) begin
      starve_d = starve_q + SW'(1);
    end

    lock_d       = lock_q;
    locked_sel_d = locked_sel_q;
    if (m_req && m_gnt) begin
      lock_d = 1'b0;
    end else if (m_req) begin
      lock_d       = 1'b1;
      locked_sel_d = sel;
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      for (int unsigned k = 0; k < MAX_OUTSTANDING; k++) begin
        owner_q[k] <= OWN_I;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      lock_q       <= 1'b0;
      locked_sel_q <= OWN_I;
      arb_err_q    <= 1'b0;
    end else begin
      if (push) begin
        owner_q[wr_ptr_q] <= sel;
        wr_ptr_q          <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q      <= count_d;
      starve_q     <= starve_d;
      lock_q       <= lock_d;
      locked_sel_q <= locked_sel_d;
      if (orphan) begin
        arb_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frv_mem_arbiter.sv
// Bench for frv_mem_arbiter: directed vector table, hand-written reset/fullness sequences,
// and constrained-random traffic, all checked against a queue-based reference model.
module tb_frv_mem_arbiter;

  localparam int MAXO   = 4;
  localparam int STARVE = 3;

  logic        g_clk, g_reset;
  logic        i_req, i_wen, i_ack, d_req, d_wen, d_ack;
  logic [3:0]  i_strb, d_strb;
  logic [31:0] i_wdata, i_addr, d_wdata, d_addr;
  logic        i_gnt, i_recv, i_error, d_gnt, d_recv, d_error;
  logic [31:0] i_rdata, d_rdata;
  logic        m_req, m_wen, m_gnt, m_recv, m_ack, m_error;
  logic [3:0]  m_strb;
  logic [31:0] m_wdata, m_addr, m_rdata;
  logic        arb_err;

  frv_mem_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(STARVE)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .i_req(i_req), .i_wen(i_wen), .i_strb(i_strb), .i_wdata(i_wdata), .i_addr(i_addr),
    .i_gnt(i_gnt), .i_recv(i_recv), .i_ack(i_ack), .i_error(i_error), .i_rdata(i_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_strb(d_strb), .d_wdata(d_wdata), .d_addr(d_addr),
    .d_gnt(d_gnt), .d_recv(d_recv), .d_ack(d_ack), .d_error(d_error), .d_rdata(d_rdata),
    .m_req(m_req), .m_wen(m_wen), .m_strb(m_strb), .m_wdata(m_wdata), .m_addr(m_addr),
    .m_gnt(m_gnt), .m_recv(m_recv), .m_ack(m_ack), .m_error(m_error), .m_rdata(m_rdata),
    .arb_err(arb_err)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: outstanding owners as a queue (1 = data), starvation as an integer.
  bit owners[$];
  int starve_m;
  bit lock_m, lockd_m, err_m;
  bit e_m_req, e_i_gnt, e_d_gnt, e_i_recv, e_d_recv, e_m_ack, e_err, e_sel_d;
  bit e_push, e_pop, e_orphan, e_starve_inc;

  task automatic model_reset();
    owners.delete();
    starve_m = 0;
    lock_m   = 0;
    lockd_m  = 0;
    err_m    = 0;
  endtask

  task automatic model_eval();
    bit want, head_d;
    int n;
    if (g_reset) model_reset();
    n = owners.size();
    head_d = (n > 0) ? owners[0] : 1'b0;
    if (lock_m) e_sel_d = lockd_m;
    else        e_sel_d = d_req && !(i_req && starve_m == STARVE);
    want     = e_sel_d ? d_req : i_req;
    e_m_req  = !g_reset && want && (n < MAXO);
    e_i_gnt  = e_m_req && m_gnt && !e_sel_d;
    e_d_gnt  = e_m_req && m_gnt && e_sel_d;
    e_i_recv = !g_reset && m_recv && n > 0 && !head_d;
    e_d_recv = !g_reset && m_recv && n > 0 && head_d;
    if (g_reset)    e_m_ack = 0;
    else if (n > 0) e_m_ack = head_d ? d_ack : i_ack;
    else            e_m_ack = m_recv;
    e_err        = err_m;
    e_push       = e_m_req && m_gnt;
    e_pop        = m_recv && e_m_ack && n > 0;
    e_orphan     = !g_reset && m_recv && n == 0;
    e_starve_inc = e_d_gnt && i_req;
  endtask

  task automatic model_commit();
    if (g_reset) begin
      model_reset();
    end else begin
      if (e_pop) void'(owners.pop_front());
      if (e_push) owners.push_back(e_sel_d);
      if (e_i_gnt) starve_m = 0;
      else if (e_starve_inc && starve_m < STARVE) starve_m++;
      if (e_push) lock_m = 0;
      else if (e_m_req) begin
        lock_m  = 1;
        lockd_m = e_sel_d;
      end
      if (e_orphan) err_m = 1;
    end
  endtask

  task automatic check_all();
    chk1("m_req", m_req, e_m_req);
    chk1("i_gnt", i_gnt, e_i_gnt);
    chk1("d_gnt", d_gnt, e_d_gnt);
    chk1("i_recv", i_recv, e_i_recv);
    chk1("d_recv", d_recv, e_d_recv);
    chk1("m_ack", m_ack, e_m_ack);
    chk1("arb_err", arb_err, e_err);
    chk32("m_addr", m_addr, e_sel_d ? d_addr : i_addr);
    chk32("m_wdata", m_wdata, e_sel_d ? d_wdata : i_wdata);
    chk32("m_strb", {28'd0, m_strb}, {28'd0, e_sel_d ? d_strb : i_strb});
    chk1("m_wen", m_wen, e_sel_d ? d_wen : i_wen);
    chk32("i_rdata", i_rdata, m_rdata);
    chk32("d_rdata", d_rdata, m_rdata);
    chk1("i_error", i_error, m_error);
    chk1("d_error", d_error, m_error);
  endtask

  // Called at posedge+1: evaluate mid-cycle, then advance across the next edge.
  task automatic pre();
    #4;
    model_eval();
    check_all();
  endtask

  task automatic post();
    @(posedge g_clk);
    model_commit();
    #1;
  endtask

  task automatic drive(input logic [5:0] in);
    {i_req, d_req, m_gnt, m_recv, i_ack, d_ack} = in;
  endtask

  typedef struct {
    logic [5:0]  in;   // i_req d_req m_gnt m_recv i_ack d_ack
    logic [31:0] rd;
    logic [7:0]  ex;   // m_req i_gnt d_gnt i_recv d_recv m_ack arb_err sel_d
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [5:0] in, input logic [31:0] rd, input logic [7:0] ex);
    vec_t v;
    v.in = in;
    v.rd = rd;
    v.ex = ex;
    tbl.push_back(v);
  endtask

  initial begin
    logic [7:0] x;
    // Idle, single data transfer and response, orphan response
    add(6'b000000, 32'h0, 8'b00000000);
    add(6'b011000, 32'h0, 8'b10100001);
    add(6'b000101, 32'hDEADBEEF, 8'b00001100);
    add(6'b000100, 32'h0, 8'b00000100);
    add(6'b000000, 32'h0, 8'b00000010);
    // Both requesting with streaming responses: D,D,D,I,D,D,D,I
    add(6'b111111, 32'h11, 8'b10100111);
    add(6'b111111, 32'h22, 8'b10101111);
    add(6'b111111, 32'h33, 8'b10101111);
    add(6'b111111, 32'h44, 8'b11001110);
    add(6'b111111, 32'h55, 8'b10110111);
    add(6'b111111, 32'h66, 8'b10101111);
    add(6'b111111, 32'h77, 8'b10101111);
    add(6'b111111, 32'h88, 8'b11001110);
    add(6'b000111, 32'h99, 8'b00010110);
    // Stalled data request locks the mux, then fetch
    add(6'b010000, 32'h0, 8'b10000011);
    add(6'b110000, 32'h0, 8'b10000011);
    add(6'b110000, 32'h0, 8'b10000011);
    add(6'b111000, 32'h0, 8'b10100011);
    add(6'b101000, 32'h0, 8'b11000010);
    // Stalled fetch request stays selected even when data arrives
    add(6'b100000, 32'h0, 8'b10000010);
    add(6'b110000, 32'h0, 8'b10000010);
    add(6'b111000, 32'h0, 8'b11000010);
    add(6'b011000, 32'h0, 8'b10100011);
    // Full FIFO blocks requests; non-owner ack ignored; pop frees slot next cycle
    add(6'b111000, 32'h0, 8'b00000011);
    add(6'b000110, 32'hA1, 8'b00001010);
    add(6'b111101, 32'hA2, 8'b00001111);
    add(6'b111000, 32'h0, 8'b10100011);
    add(6'b000111, 32'hB1, 8'b00010110);
    add(6'b000111, 32'hB2, 8'b00010110);
    add(6'b000111, 32'hB3, 8'b00001110);
    add(6'b000111, 32'hB4, 8'b00001110);

    i_wen = 1'b0; i_strb = 4'hF; i_wdata = 32'h1111_0000; i_addr = 32'h0000_2000;
    d_wen = 1'b1; d_strb = 4'h3; d_wdata = 32'h2222_0000; d_addr = 32'h0000_0100;
    m_rdata = '0; m_error = 1'b0;
    drive(6'b000000);
    g_reset = 1'b1;
    model_reset();

    // Outputs forced low during reset even with activity on the inputs
    @(posedge g_clk); #1;
    drive(6'b111111);
    pre();
    post();
    g_reset = 1'b0;
    drive(6'b000000);

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].in);
      m_rdata = tbl[k].rd;
      m_error = tbl[k].rd[0];
      pre();
      x = tbl[k].ex;
      chk1($sformatf("tbl[%0d].m_req", k),   m_req,   x[7]);
      chk1($sformatf("tbl[%0d].i_gnt", k),   i_gnt,   x[6]);
      chk1($sformatf("tbl[%0d].d_gnt", k),   d_gnt,   x[5]);
      chk1($sformatf("tbl[%0d].i_recv", k),  i_recv,  x[4]);
      chk1($sformatf("tbl[%0d].d_recv", k),  d_recv,  x[3]);
      chk1($sformatf("tbl[%0d].m_ack", k),   m_ack,   x[2]);
      chk1($sformatf("tbl[%0d].arb_err", k), arb_err, x[1]);
      chk32($sformatf("tbl[%0d].m_addr", k), m_addr,  x[0] ? d_addr : i_addr);
      post();
    end

    // Fill to three outstanding, then stall a fourth (lock to data) and reset asynchronously
    drive(6'b101000); pre(); chk1("burst.i_gnt", i_gnt, 1'b1); post();
    drive(6'b011000); pre(); chk1("burst.d_gnt", d_gnt, 1'b1); post();
    drive(6'b101000); pre(); chk1("burst.i_gnt2", i_gnt, 1'b1); post();
    drive(6'b010000); pre(); chk1("burst.stall", m_req, 1'b1); post();
    drive(6'b110111);
    #2;
    g_reset = 1'b1;
    #1;
    chk1("rst.m_req", m_req, 1'b0);
    chk1("rst.i_gnt", i_gnt, 1'b0);
    chk1("rst.d_gnt", d_gnt, 1'b0);
    chk1("rst.i_recv", i_recv, 1'b0);
    chk1("rst.d_recv", d_recv, 1'b0);
    chk1("rst.m_ack", m_ack, 1'b0);
    chk1("rst.arb_err", arb_err, 1'b0);
    #1;
    model_eval();
    check_all();
    post();
    g_reset = 1'b0;
    // Lock and count must be gone: fetch alone wins, response is an orphan
    drive(6'b101100);
    pre();
    chk1("post_rst.i_gnt", i_gnt, 1'b1);
    chk32("post_rst.m_addr", m_addr, i_addr);
    chk1("post_rst.m_ack", m_ack, 1'b1);
    chk1("post_rst.i_recv", i_recv, 1'b0);
    chk1("post_rst.arb_err", arb_err, 1'b0);
    post();
    drive(6'b000111); pre(); chk1("post_rst.drain", i_recv, 1'b1); post();

    // Random traffic; requesters hold request and payload until granted
    for (int c = 0; c < 3000; c++) begin
      if (!(i_req && !e_i_gnt)) begin
        i_req   = ($urandom_range(0, 99) < 55);
        i_wen   = 1'($urandom);
        i_strb  = 4'($urandom);
        i_wdata = $urandom;
        i_addr  = $urandom;
      end
      if (!(d_req && !e_d_gnt)) begin
        d_req   = ($urandom_range(0, 99) < 55);
        d_wen   = 1'($urandom);
        d_strb  = 4'($urandom);
        d_wdata = $urandom;
        d_addr  = $urandom;
      end
      m_gnt   = ($urandom_range(0, 99) < 65);
      m_recv  = ($urandom_range(0, 99) < 45);
      i_ack   = ($urandom_range(0, 99) < 70);
      d_ack   = ($urandom_range(0, 99) < 70);
      m_rdata = $urandom;
      m_error = 1'($urandom);
      pre();
      post();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
